ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Request/response front end that drives the single-port synchronous word RAM (one-cycle registered read, read-before-write, full-word write enable only). It accepts byte-addressed read and write requests with byte enables over a valid/ready handshake and sequences the RAM port. Partial writes are done as read-modify-write. Exactly one transaction is in flight at a time. It sits between the core's load/store unit and the RAM instance.

## Interface
- dat_width, 32, data width in bits; power of two, at least 8
- adr_width, 32, address width for both the request (byte address) and the RAM port (word address)
- mem_size, 1024, RAM depth in words
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid and ready are both high at an edge
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  adr_width  byte address; low log2(dat_width/8) bits ignored
- req_be_i  in  dat_width/8  byte enables; ignored for reads
- req_dat_i  in  dat_width  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid and ready are both high at an edge
- rsp_dat_o  out  dat_width  read data; 0 for writes and errors
- rsp_err_o  out  1  address out of range
- ram_adr_o  out  adr_width  word address to RAM adr_i
- ram_we_o  out  1  to RAM we_i
- ram_dat_o  out  dat_width  to RAM dat_i
- ram_dat_i  in  dat_width  from RAM dat_o

## Operation
- FSM states: IDLE, ACC, WAIT, WR, RESP.
- req_ready_o = (state == IDLE) && rst_n.
- Handshake in IDLE: register the word address (req_adr_i >> log2(dat_width/8)), we, be and data. Compute err = (word address >= mem_size). Go to ACC.
- ACC: ram_adr_o = registered word address.
  - err: no RAM write; go to RESP with rsp_err_o = 1 and rsp_dat_o = 0.
  - Write with be all ones: ram_we_o = 1, ram_dat_o = req data; go to RESP.
  - Write with be all zeros: no RAM write; go to RESP.
  - Read or partial write: go to WAIT.
- WAIT: ram_dat_i holds the addressed word.
  - Read: capture it into rsp_dat_o; go to RESP.
  - Partial write: build the merged word, taking byte i from req_dat_i when be[i] = 1 and from ram_dat_i otherwise; go to WR.
- WR: ram_adr_o is unchanged; ram_we_o = 1 and ram_dat_o = merged word; go to RESP.
- RESP: rsp_valid_o = 1. rsp_dat_o and rsp_err_o are held stable. Go to IDLE on the response handshake.
- Requests presented outside IDLE are not accepted and have no effect.
- ram_we_o is a registered-state decode ANDed with rst_n, so no RAM write happens at any edge where rst_n is low.

## Timing
- Request handshake at edge N.
- Response valid (rsp_valid_o high) from edge:
  - N+1: full write, be = 0 write, error
  - N+2: read
  - N+3: partial write
- The RAM write is sampled at edge N+1 for a full write and at edge N+3 for a partial write.
- req_ready_o returns high on the cycle after the response handshake.
- Minimum issue interval, request to next request with rsp_ready_i held high: 3 cycles full write, 4 cycles read, 5 cycles partial write.
- Reset values, also forced on every edge where rst_n is low: state IDLE; rsp_valid_o, rsp_err_o, rsp_dat_o, ram_we_o, ram_adr_o and ram_dat_o all 0. req_ready_o is 0 while rst_n is low and 1 on the first cycle after release.
- Reset mid-transaction: the transaction is abandoned with no response. A partial write reset before WR leaves the RAM word unchanged. Reset during WR also suppresses the write.
- Highest valid word address is mem_size-1. Address bits above the range always produce an error and never wrap.

## Test plan
- Reset: hold rst_n low 3 cycles with req_valid_i = 1 -> no acceptance, all outputs 0, ram_we_o never 1; after release req_ready_o = 1.
- Full write then read: write 0xDEADBEEF to byte address 0x10 with be = 0xF -> ram_we_o at edge N+1 with ram_adr_o = 4, response at N+1. Then read 0x10 -> rsp_dat_o = 0xDEADBEEF at N+2, rsp_err_o = 0.
- Partial write: word 4 holds 0xDEADBEEF; write 0x11223344 with be = 0b0101 -> response at N+3; subsequent read returns 0xDE22BE44.
- Out-of-range address: access byte address 0x1000 (word 1024), read and write -> rsp_err_o = 1, rsp_dat_o = 0, ram_we_o stays 0, word 0 unchanged.
- Backpressure: hold rsp_ready_i low 5 cycles after a read response -> rsp_valid_o, rsp_dat_o and rsp_err_o stable; req_ready_o = 0; a competing request is ignored until the response handshake.
- Reset in WR: assert rst_n low in the WR state of a be = 0b0001 write -> no RAM write; FSM in IDLE; word reads back as its original value.

Source files
------------

// File: rtl/ram_ctrl.sv
// Valid/ready front end for a single-port synchronous word RAM.
// Byte-enable partial writes are done as read-modify-write; one transaction in flight.
module ram_ctrl #(
  parameter int dat_width = 32,
  parameter int adr_width = 32,
  parameter int mem_size  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [adr_width-1:0]   req_adr_i,
  input  logic [dat_width/8-1:0] req_be_i,
  input  logic [dat_width-1:0]   req_dat_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [dat_width-1:0]   rsp_dat_o,
  output logic                   rsp_err_o,
  output logic [adr_width-1:0]   ram_adr_o,
  output logic                   ram_we_o,
  output logic [dat_width-1:0]   ram_dat_o,
  input  logic [dat_width-1:0]   ram_dat_i
);
  localparam int NB = dat_width / 8;
  localparam int AB = $clog2(NB);
  localparam logic [adr_width-1:0] MEM_WORDS = adr_width'(mem_size);

  typedef enum logic [2:0] {IDLE, ACC, WAIT, WR, RESP} state_t;

  state_t               state_q, state_d;
  logic [adr_width-1:0] adr_q, adr_d;
  logic                 we_q, we_d;
  logic [NB-1:0]        be_q, be_d;
  logic [dat_width-1:0] dat_q, dat_d;
  logic                 err_q, err_d;
  logic [dat_width-1:0] rdat_q, rdat_d;
  logic                 rerr_q, rerr_d;
  logic [dat_width-1:0] merged;
  logic [adr_width-1:0] wadr;

  assign wadr = req_adr_i >> AB;

  // Byte lanes of the read-modify-write merge.
  for (genvar i = 0; i < NB; i++) begin : g_merge
    assign merged[8*i +: 8] = be_q[i] ? dat_q[8*i +: 8] : ram_dat_i[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    be_d    = be_q;
    dat_d   = dat_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        adr_d   = wadr;
        we_d    = req_we_i;
        be_d    = req_be_i;
        dat_d   = req_dat_i;
        err_d   = (wadr >= MEM_WORDS);
        rdat_d  = '0;
        rerr_d  = 1'b0;
        state_d = ACC;
      end
      ACC: begin
        if (err_q) begin
          rerr_d  = 1'b1;
          state_d = RESP;
        end else if (we_q && ((&be_q) || !(|be_q))) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (we_q) begin
          dat_d   = merged;
          state_d = WR;
        end else begin
          rdat_d  = ram_dat_i;
          state_d = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
    end
  end

  // Write strobe gated by rst_n so a reset edge never commits a RAM write.
  assign ram_we_o    = rst_n && ((state_q == ACC && we_q && !err_q && (&be_q)) ||
                                 (state_q == WR));
  assign ram_adr_o   = adr_q;
  assign ram_dat_o   = dat_q;
  assign req_ready_o = (state_q == IDLE) && rst_n;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rdat_q;
  assign rsp_err_o   = rerr_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: stimulus pushes expected responses and RAM writes,
// a negedge monitor pops and compares them, including latency in cycles.
module tb_ram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = '0;
  logic [3:0]  req_be_i = '0;
  logic [31:0] req_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic [31:0] ram_adr_o;
  logic        ram_we_o;
  logic [31:0] ram_dat_o;
  logic [31:0] ram_dat_i;

  ram_ctrl #(.dat_width(32), .adr_width(32), .mem_size(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_be_i(req_be_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .ram_adr_o(ram_adr_o), .ram_we_o(ram_we_o), .ram_dat_o(ram_dat_o),
    .ram_dat_i(ram_dat_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM: registered read, read-before-write.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
  always @(posedge clk) begin
    if (ram_we_o === 1'b1 && ram_adr_o < 1024) mem[ram_adr_o[9:0]] <= ram_dat_o;
    ram_dat_i <= (ram_adr_o < 1024) ? mem[ram_adr_o[9:0]] : 32'h0;
  end

  typedef struct { logic [31:0] dat; logic err; int due; } rsp_t;
  typedef struct { logic [31:0] adr; logic [31:0] dat; int due; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compares every presented response and every RAM write strobe.
  bit seen = 0;
  bit post_hs = 0;
  always @(negedge clk) begin
    if (post_hs) begin
      chk("ready_after_rsp", req_ready_o, 1);
      post_hs = 0;
    end
    if (rsp_valid_o === 1'b1) begin
      if (rq.size() == 0) fail("unexpected_rsp");
      else begin
        if (!seen) chk("rsp_latency", cyc, rq[0].due);
        seen = 1;
        chk("rsp_dat", rsp_dat_o, rq[0].dat);
        chk("rsp_err", rsp_err_o, rq[0].err);
        if (rsp_ready_i) begin
          void'(rq.pop_front());
          seen = 0;
          post_hs = 1;
        end
      end
    end
    if (ram_we_o !== 1'b0 && rst_n !== 1'b0 || ram_we_o === 1'b1) begin
      if (wq.size() == 0) fail("unexpected_ram_write");
      else begin
        chk("wr_edge", cyc + 1, wq[0].due);
        chk("wr_adr", ram_adr_o, wq[0].adr);
        chk("wr_dat", ram_dat_o, wq[0].dat);
        void'(wq.pop_front());
      end
    end
  end

  task automatic send(input bit we, input logic [31:0] adr, input logic [3:0] be,
                      input logic [31:0] dat, input bit ersp, input logic [31:0] edat,
                      input bit eerr, input int lat, input bit wexp,
                      input logic [31:0] wadr, input logic [31:0] wdat, input int wlat);
    int n = 0;
    rsp_t r;
    wr_t  w;
    req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_be_i = be; req_dat_i = dat;
    forever begin
      @(negedge clk);
      if (req_ready_o === 1'b1) break;
      n++;
      if (n > 50) begin
        fail("req_accept_timeout");
        req_valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (ersp) begin r.dat = edat; r.err = eerr; r.due = cyc + lat; rq.push_back(r); end
    if (wexp) begin w.adr = wadr; w.dat = wdat; w.due = cyc + wlat; wq.push_back(w); end
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      fail("drain_timeout");
      rq.delete();
      wq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with a request pending: nothing accepted, outputs cleared.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h10; req_be_i = 4'hF;
    req_dat_i = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_dat", rsp_dat_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      chk("rst_ram_we", ram_we_o, 0);
      chk("rst_ram_adr", ram_adr_o, 0);
      chk("rst_ram_dat", ram_dat_o, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid_i = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready_o, 1);
    @(posedge clk); #1;

    // Full write, then read back.
    send(1, 32'h10, 4'hF, 32'hDEADBEEF, 1, 32'h0, 0, 1, 1, 32'd4, 32'hDEADBEEF, 1);
    drain();
    send(0, 32'h10, 4'h0, 32'h0, 1, 32'hDEADBEEF, 0, 2, 0, 0, 0, 0);
    drain();

    // Partial write with be=0101 merges bytes 0 and 2.
    send(1, 32'h10, 4'b0101, 32'h11223344, 1, 32'h0, 0, 3, 1, 32'd4, 32'hDE22BE44, 3);
    drain();
    send(0, 32'h12, 4'h0, 32'h0, 1, 32'hDE22BE44, 0, 2, 0, 0, 0, 0);
    drain();

    // be=0 write: response only, RAM untouched.
    send(1, 32'h14, 4'h0, 32'hFFFF_FFFF, 1, 32'h0, 0, 1, 0, 0, 0, 0);
    drain();
    send(0, 32'h14, 4'h0, 32'h0, 1, 32'hA500_0005, 0, 2, 0, 0, 0, 0);
    drain();

    // Out-of-range: word 1024, high address bits, and the last valid word.
    send(0, 32'h1000, 4'h0, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0);
    drain();
    send(1, 32'h1000, 4'hF, 32'hCAFE_F00D, 1, 32'h0, 1, 1, 0, 0, 0, 0);
    drain();
    send(1, 32'h1000, 4'h3, 32'hCAFE_F00D, 1, 32'h0, 1, 1, 0, 0, 0, 0);
    drain();
    send(1, 32'h8000_0000, 4'hF, 32'hCAFE_F00D, 1, 32'h0, 1, 1, 0, 0, 0, 0);
    drain();
    send(0, 32'h8000_0010, 4'h0, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0);
    drain();
    send(0, 32'h0, 4'h0, 32'h0, 1, 32'hA500_0000, 0, 2, 0, 0, 0, 0);
    drain();
    send(0, 32'hFFC, 4'h0, 32'h0, 1, 32'hA500_03FF, 0, 2, 0, 0, 0, 0);
    drain();

    // Backpressure with a competing write that must be ignored.
    rsp_ready_i = 1'b0;
    send(0, 32'h10, 4'h0, 32'h0, 1, 32'hDE22BE44, 0, 2, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h20; req_be_i = 4'hF;
    req_dat_i = 32'h5555_5555;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", req_ready_o, 0);
      chk("bp_rsp_valid", rsp_valid_o, 1);
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    drain();

    // Reset while in WR of a be=0001 write: write suppressed, FSM back to IDLE.
    send(1, 32'h20, 4'b0001, 32'h0000_00FF, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wr_reset_we", ram_we_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_reset_idle", req_ready_o, 1);
    chk("wr_reset_no_rsp", rsp_valid_o, 0);
    @(posedge clk); #1;
    send(0, 32'h20, 4'h0, 32'h0, 1, 32'hA500_0008, 0, 2, 0, 0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
